// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift/rotate unit.
// Optional carry output is enabled by defining SHIFT_CARRY_EN.
package shift_pkg;

    typedef enum logic [2:0] {
        SHR  = 3'b000,
        SHRA = 3'b001,
        SHL  = 3'b010,
        ROR  = 3'b011,
        ROL  = 3'b100
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by k positions (0..STEP)
// and reports the last bit that left the word.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 6
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] shifted,
    output logic             last_out
);

    logic [KW-1:0]    k_inv;
    logic [KW-1:0]    k_m1;
    logic [WIDTH-1:0] r_probe;
    logic [WIDTH-1:0] l_probe;

    always_comb begin
        k_inv    = KW'(WIDTH) - k;
        k_m1     = k - KW'(1);
        // The last bit out is the one sitting k-1 places from the exit edge.
        r_probe  = value >> k_m1;
        l_probe  = value << k_m1;
        shifted  = value;
        last_out = 1'b0;
        case (op)
            SHR: begin
                shifted  = value >> k;
                last_out = r_probe[0];
            end
            SHRA: begin
                shifted  = $unsigned($signed(value) >>> k);
                last_out = r_probe[0];
            end
            SHL: begin
                shifted  = value << k;
                last_out = l_probe[WIDTH-1];
            end
            ROR: begin
                shifted  = (value >> k) | (value << k_inv);
                last_out = r_probe[0];
            end
            ROL: begin
                shifted  = (value << k) | (value >> k_inv);
                last_out = l_probe[WIDTH-1];
            end
            default: begin
                shifted  = value;
                last_out = 1'b0;
            end
        endcase
        if (k == '0) begin
            last_out = 1'b0;
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit with start/done handshake, up to STEP bits per clock.
// Define SHIFT_CARRY_EN to add the carry_out port.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
`ifdef SHIFT_CARRY_EN
    ,
    output logic             carry_out
`endif
);

    localparam int AW = $clog2(WIDTH);
    localparam int KW = AW + 1;

    state_e           state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [AW-1:0]    count, count_nx, count_dec, amt;
    logic [2:0]       op_q, op_nx;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_val;
    logic             step_last;
    logic             unused_b_hi;

    assign unused_b_hi = ^B[WIDTH-1:AW];
    assign result      = work;

    shift_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .value    (work),
        .op       (op_q),
        .k        (k),
        .shifted  (step_val),
        .last_out (step_last)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= IDLE;
            work  <= '0;
            count <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            count <= count_nx;
            op_q  <= op_nx;
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        state_nx  = state;
        work_nx   = work;
        count_nx  = count;
        op_nx     = op_q;
        amt       = B[AW-1:0];
        k         = ({1'b0, count} < KW'(STEP)) ? {1'b0, count} : KW'(STEP);
        count_dec = count - k[AW-1:0];
        case (state)
            IDLE: begin
                if (start) begin
                    work_nx  = A;
                    op_nx    = op;
                    count_nx = op_is_valid(op) ? amt : '0;
                    state_nx = (op_is_valid(op) && amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_nx  = step_val;
                count_nx = count_dec;
                state_nx = (count_dec == '0) ? DONE : SHIFT;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef SHIFT_CARRY_EN
    always_ff @(posedge Clock) begin
        if (Clear) begin
            carry_out <= 1'b0;
        end else if (state == IDLE && start) begin
            carry_out <= 1'b0;
        end else if (state == SHIFT) begin
            carry_out <= step_last;
        end
    end
`else
    logic unused_last;
    assign unused_last = step_last;
`endif

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench: two shift_unit instances (STEP=1 and STEP=4) share one stimulus stream.
module tb_shift_unit;
    import shift_pkg::*;

    localparam int W = 32;

    logic          Clock = 1'b0;
    logic          Clear, start;
    logic [2:0]    op;
    logic [W-1:0]  A, B;
    logic [W-1:0]  res1, res4;
    logic          busy1, busy4, done1, done4;
    logic          co1, co4;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        int unsigned  lat;
        int unsigned  acc;
    } exp_t;

    exp_t        sb1[$];
    exp_t        sb4[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
        .Clock(Clock), .Clear(Clear), .start(start), .op(op), .A(A), .B(B),
        .result(res1), .busy(busy1), .done(done1)
`ifdef SHIFT_CARRY_EN
        , .carry_out(co1)
`endif
    );

    shift_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
        .Clock(Clock), .Clear(Clear), .start(start), .op(op), .A(A), .B(B),
        .result(res4), .busy(busy4), .done(done4)
`ifdef SHIFT_CARRY_EN
        , .carry_out(co4)
`endif
    );

`ifndef SHIFT_CARRY_EN
    assign co1 = 1'b0;
    assign co4 = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: amt single-bit steps, tracking the last bit out.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output int unsigned amt);
        logic [4:0] b_lo;
        b_lo = b[4:0];
        r    = a;
        c    = 1'b0;
        amt  = (o > 3'd4) ? 0 : int'(b_lo);
        for (int unsigned i = 0; i < amt; i++) begin
            case (o)
                3'd0: begin c = r[0];   r = {1'b0, r[W-1:1]};   end
                3'd1: begin c = r[0];   r = {r[W-1], r[W-1:1]}; end
                3'd2: begin c = r[W-1]; r = {r[W-2:0], 1'b0};   end
                3'd3: begin c = r[0];   r = {r[0], r[W-1:1]};   end
                default: begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end
            endcase
        end
    endfunction

    task automatic score(input int d, input string nm, input logic bz, input logic [W-1:0] r, input logic co);
        exp_t e;
        int   n;
        n = (d == 0) ? sb1.size() : sb4.size();
        if (n == 0) begin
            check_eq({nm, "_spurious_done"}, 64'd1, 64'd0);
        end else begin
            e = (d == 0) ? sb1.pop_front() : sb4.pop_front();
            check_eq({nm, "_result"}, r, e.res);
            check_eq({nm, "_latency"}, cyc - e.acc + 1, e.lat);
            check_eq({nm, "_busy_with_done"}, bz, 1'b1);
`ifdef SHIFT_CARRY_EN
            check_eq({nm, "_carry"}, co, e.c);
`endif
        end
    endtask

    always @(negedge Clock) begin
        if (done1) score(0, "dut1", busy1, res1, co1);
        if (done4) score(1, "dut4", busy4, res4, co4);
    end

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            if (!busy1 && !busy4) idle = 1'b1;
            else @(negedge Clock);
        end
        if (!idle) check_eq("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [W-1:0] r;
        logic        c;
        int unsigned amt;
        wait_idle();
        model(o, a, b, r, c, amt);
        e.res = r;
        e.c   = c;
        e.acc = cyc + 1;
        e.lat = (amt == 0) ? 1 : amt + 1;
        sb1.push_back(e);
        e.lat = (amt == 0) ? 1 : (amt + 3) / 4 + 1;
        sb4.push_back(e);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        op = 3'($urandom); A = $urandom; B = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Clear = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        repeat (3) @(negedge Clock);
        check_eq("reset_result1", res1, 0);
        check_eq("reset_result4", res4, 0);
        check_eq("reset_busy", {busy1, busy4}, 0);
        check_eq("reset_done", {done1, done4}, 0);
        check_eq("reset_carry", {co1, co4}, 0);
        Clear = 1'b0;
        @(negedge Clock);

        issue(SHR, 32'd15, 32'd2);
        check_eq("busy_after_accept", {busy1, busy4}, 2'b11);
        wait_idle();
        @(negedge Clock);
        check_eq("hold_result1", res1, 32'd3);
        check_eq("idle_busy", {busy1, busy4}, 0);

        issue(SHRA, 32'h8000_0010, 32'd4);
        issue(ROR,  32'h0000_0001, 32'd1);
        issue(ROL,  32'h1234_5678, 32'd8);
        issue(SHL,  32'd1, 32'd37);
        issue(SHR,  32'hCAFE_F00D, 32'd32);
        issue(3'b111, 32'hDEAD_BEEF, 32'd5);
        issue(3'b101, 32'h0BAD_CAFE, 32'd9);
        issue(SHL,  32'hFFFF_FFFF, 32'd31);
        issue(ROR,  32'h8000_0001, 32'd31);

        // start pulsed mid-shift must be ignored
        issue(SHR, 32'hFFFF_0000, 32'd20);
        @(negedge Clock);
        op = SHL; A = 32'd1; B = 32'd3; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge Clock);
        check_eq("no_stray_accept", {busy1, busy4}, 0);

        // Clear mid-shift, asserted together with start
        issue(ROL, 32'hA5A5_0F0F, 32'd10);
        @(negedge Clock);
        Clear = 1'b1; start = 1'b1; op = SHL; A = 32'h55; B = 32'd3;
        @(negedge Clock);
        Clear = 1'b0; start = 1'b0;
        sb1.delete(); sb4.delete();
        check_eq("clear_result1", res1, 0);
        check_eq("clear_result4", res4, 0);
        check_eq("clear_busy", {busy1, busy4}, 0);
        check_eq("clear_done", {done1, done4}, 0);
        check_eq("clear_carry", {co1, co4}, 0);
        issue(SHRA, 32'h9000_0000, 32'd10);

        for (int i = 0; i < 12; i++) begin
            issue(3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        wait_idle();
        repeat (2) @(negedge Clock);
        check_eq("sb1_drained", sb1.size(), 0);
        check_eq("sb4_drained", sb4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Multi-cycle, parametrised shift/rotate unit for the bus-based datapath.
- Replaces the single-op combinational SHR path in the ALU.
- A operand is loaded from Y and the shift amount from the bus. Result is written to Z via the existing Zin/Zlowout sequencing.
- Supports five ops (SHR, SHRA, SHL, ROR, ROL) and shifts up to STEP bits per clock, with a start/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2, ≥ 4.
- STEP, 1, maximum bit positions shifted per clock; 1 ≤ STEP ≤ WIDTH.
- AW, $clog2(WIDTH), derived, width of the effective shift amount.

Ports:
- Clock  in  1  system clock; rising edge.
- Clear  in  1  synchronous active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  3  operation select (encodings in package).
- A  in  WIDTH  value to shift (from Y).
- B  in  WIDTH  shift amount; only B[AW-1:0] is used.
- result  out  WIDTH  shifted value; held stable until the next accepted start.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; result is valid in the same cycle.

Behaviour:
- Reset: on a Clear edge, state is IDLE and result, busy and done are 0. This applies in any state, including mid-shift, and the operation is abandoned.
- States and transitions:
  - IDLE → SHIFT on start when amt ≠ 0.
  - IDLE → DONE on start when amt = 0.
  - SHIFT → SHIFT while the remaining count is > 0 after this edge's step.
  - SHIFT → DONE when the count reaches 0.
  - DONE → IDLE unconditionally.
- Accept edge (IDLE and start): work register ← A, count ← B[AW-1:0], op latched. The effective amount is B mod WIDTH.
- Each SHIFT edge:
  - k = min(STEP, count).
  - work ← one-step shift of work by k per the latched op.
  - count ← count − k.
- Op semantics:
  - SHR: logical right, zero fill.
  - SHRA: arithmetic right, fill with the sign bit.
  - SHL: left, zero fill.
  - ROR / ROL: rotate.
  - Reserved encodings: pass A through unchanged, with count forced to 0.
- Latency: done is asserted ceil(amt/STEP)+1 cycles after the accept edge.
  - amt = 0: done in the cycle after the accept edge.
  - WIDTH = 32, STEP = 1, amt = 31: 32 cycles.
- result equals the work register. It is driven from the register only, so no combinational path runs from A or B.
- start while busy is ignored; there is no queuing. start held high through DONE is re-accepted only on the first edge in IDLE.
- Simultaneous Clear and start: Clear wins.
- op, A and B may change after the accept edge without affecting the operation in flight.

Optional Feature:
- Macro: SHIFT_CARRY_EN.
- Defined:
  - Adds output port carry_out (1 bit), reset to 0.
  - Cleared on the accept edge. On each SHIFT edge it takes the last bit shifted out: for right ops the bit leaving position 0; for SHL and ROL the bit leaving position WIDTH-1. For rotates this is the wrapped bit.
  - Holds its value with result; stays 0 when amt = 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package shift_pkg:
  - Op encodings: SHR=3'b000, SHRA=3'b001, SHL=3'b010, ROR=3'b011, ROL=3'b100.
  - State encoding: IDLE, SHIFT, DONE.
- Sub-module shift_step: purely combinational.
  - Inputs: WIDTH-bit value, op, k (0..STEP).
  - Outputs: shifted value and the last bit out.
  - Instantiated once; shift_unit holds the FSM, count and registers.

Test Plan:
- WIDTH=32, STEP=1, op=SHR, A=32'd15, B=32'd2 (reset applied first) → done 3 cycles after accept; result=32'd3; busy high for 3 cycles.
- SHRA, A=32'h8000_0010, B=4 → result=32'hF800_0001. ROR, A=32'h0000_0001, B=1 → result=32'h8000_0000, with carry_out=1 when SHIFT_CARRY_EN is defined.
- STEP=4, ROL, A=32'h1234_5678, B=8 → done 3 cycles after accept; result=32'h3456_7812. B=32'd37 (37 mod 32 = 5) with SHL, A=1 → result=32'h20.
- amt=0 (B=32'd32) and reserved op 3'b111 → done in the cycle after accept; result=A.
- start pulsed during SHIFT with different operands → ignored; the original result completes with unchanged latency.
- Clear asserted mid-shift (cycle 2 of a 10-bit shift), then a new start → result, busy and done are 0 after the Clear edge; the new operation completes correctly from IDLE.
